// File: rtl/ps2_text_pkg.sv
// Shared types and constants for the PS/2 to text-buffer path.
// States, set-2 scan codes and the ASCII fill value used by backspace.
package ps2_text_pkg;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_BREAK = 2'd1,
        S_EXT   = 2'd2,
        S_WRITE = 2'd3
    } state_t;

    localparam logic [7:0] SC_BREAK  = 8'hF0;
    localparam logic [7:0] SC_EXT    = 8'hE0;
    localparam logic [7:0] SC_LSHIFT = 8'h12;
    localparam logic [7:0] SC_RSHIFT = 8'h59;
    localparam logic [7:0] SC_ENTER  = 8'h5A;
    localparam logic [7:0] SC_BKSP   = 8'h66;
    localparam logic [7:0] SC_UP     = 8'h75;
    localparam logic [7:0] SC_DOWN   = 8'h72;
    localparam logic [7:0] SC_LEFT   = 8'h6B;
    localparam logic [7:0] SC_RIGHT  = 8'h74;

    localparam logic [7:0] ASCII_SPACE = 8'h20;

    function automatic logic is_shift(input logic [7:0] code);
        return (code == SC_LSHIFT) || (code == SC_RSHIFT);
    endfunction

endpackage

// File: rtl/ps2_scancode_ascii.sv
// Combinational set-2 scan code to ASCII lookup; returns 0 for unmapped codes.
// Covers letters, digits, space and the basic punctuation keys.
module ps2_scancode_ascii
    import ps2_text_pkg::*;
(
    input  logic [7:0] code,
    input  logic       shift,
    output logic [7:0] ascii
);

    logic [7:0] lo;
    logic [7:0] hi;

    always_comb begin
        lo = 8'h00;
        hi = 8'h00;
        case (code)
            8'h1C: begin lo = "a"; hi = "A"; end
            8'h32: begin lo = "b"; hi = "B"; end
            8'h21: begin lo = "c"; hi = "C"; end
            8'h23: begin lo = "d"; hi = "D"; end
            8'h24: begin lo = "e"; hi = "E"; end
            8'h2B: begin lo = "f"; hi = "F"; end
            8'h34: begin lo = "g"; hi = "G"; end
            8'h33: begin lo = "h"; hi = "H"; end
            8'h43: begin lo = "i"; hi = "I"; end
            8'h3B: begin lo = "j"; hi = "J"; end
            8'h42: begin lo = "k"; hi = "K"; end
            8'h4B: begin lo = "l"; hi = "L"; end
            8'h3A: begin lo = "m"; hi = "M"; end
            8'h31: begin lo = "n"; hi = "N"; end
            8'h44: begin lo = "o"; hi = "O"; end
            8'h4D: begin lo = "p"; hi = "P"; end
            8'h15: begin lo = "q"; hi = "Q"; end
            8'h2D: begin lo = "r"; hi = "R"; end
            8'h1B: begin lo = "s"; hi = "S"; end
            8'h2C: begin lo = "t"; hi = "T"; end
            8'h3C: begin lo = "u"; hi = "U"; end
            8'h2A: begin lo = "v"; hi = "V"; end
            8'h1D: begin lo = "w"; hi = "W"; end
            8'h22: begin lo = "x"; hi = "X"; end
            8'h35: begin lo = "y"; hi = "Y"; end
            8'h1A: begin lo = "z"; hi = "Z"; end
            8'h45: begin lo = "0"; hi = ")"; end
            8'h16: begin lo = "1"; hi = "!"; end
            8'h1E: begin lo = "2"; hi = "@"; end
            8'h26: begin lo = "3"; hi = "#"; end
            8'h25: begin lo = "4"; hi = "$"; end
            8'h2E: begin lo = "5"; hi = "%"; end
            8'h36: begin lo = "6"; hi = "^"; end
            8'h3D: begin lo = "7"; hi = "&"; end
            8'h3E: begin lo = "8"; hi = "*"; end
            8'h46: begin lo = "9"; hi = "("; end
            8'h29: begin lo = ASCII_SPACE; hi = ASCII_SPACE; end
            8'h41: begin lo = ","; hi = "<"; end
            8'h49: begin lo = "."; hi = ">"; end
            8'h4A: begin lo = "/"; hi = "?"; end
            8'h4C: begin lo = ";"; hi = ":"; end
            8'h52: begin lo = 8'h27; hi = 8'h22; end
            8'h4E: begin lo = "-"; hi = "_"; end
            8'h55: begin lo = "="; hi = "+"; end
            8'h54: begin lo = "["; hi = "{"; end
            8'h5B: begin lo = "]"; hi = "}"; end
            8'h5D: begin lo = 8'h5C; hi = "|"; end
            8'h0E: begin lo = 8'h60; hi = "~"; end
            default: begin lo = 8'h00; hi = 8'h00; end
        endcase
        ascii = shift ? hi : lo;
    end

endmodule

// File: rtl/ps2_text_writer.sv
// Turns PS/2 set-2 scan codes into character-buffer writes and tracks the cursor.
// Optional macro PS2_TEXT_WRITER_ARROW_EN: E0-prefixed arrow keys move the cursor.
//   state   | meaning
//   S_IDLE  | waiting for a make code, shift, enter, backspace or prefix
//   S_BREAK | F0 seen, next byte is a released key
//   S_EXT   | E0 seen, next byte is an extended key
//   S_WRITE | one-cycle write strobe, cursor update applied on exit
module ps2_text_writer
    import ps2_text_pkg::*;
#(
    parameter int COLS   = 70,
    parameter int ROWS   = 30,
    parameter int ADDR_W = 12
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [7:0]        code_data,
    input  logic              code_valid,
    output logic              code_ready,
    output logic              wr_en,
    output logic [ADDR_W-1:0] wr_addr,
    output logic [7:0]        wr_data,
    output logic [4:0]        cursor_row,
    output logic [6:0]        cursor_col,
    output logic [7:0]        key_count
);

    localparam logic [4:0]        LAST_ROW = 5'(ROWS - 1);
    localparam logic [6:0]        LAST_COL = 7'(COLS - 1);
    localparam logic [ADDR_W-1:0] COLS_A   = ADDR_W'(COLS);
    localparam logic [ADDR_W-1:0] ONE_A    = ADDR_W'(1);

    state_t            state_q, state_d;
    logic [4:0]        row_q, row_d;
    logic [6:0]        col_q, col_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic              shift_q, shift_d;
    logic [7:0]        cnt_q, cnt_d;
    logic [ADDR_W-1:0] wa_q, wa_d;
    logic [7:0]        wd_q, wd_d;
    logic [4:0]        pend_row_q, pend_row_d;
    logic [6:0]        pend_col_q, pend_col_d;
    logic [ADDR_W-1:0] pend_addr_q, pend_addr_d;
    logic              pend_print_q, pend_print_d;
    logic [7:0]        ascii;
    logic              take;

    ps2_scancode_ascii u_lut (
        .code  (code_data),
        .shift (shift_q),
        .ascii (ascii)
    );

    assign code_ready = (state_q != S_WRITE);
    assign wr_en      = (state_q == S_WRITE);
    assign take       = code_valid && code_ready;

    assign wr_addr    = wa_q;
    assign wr_data    = wd_q;
    assign cursor_row = row_q;
    assign cursor_col = col_q;
    assign key_count  = cnt_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state_q <= S_IDLE;
        else     state_q <= state_d;
    end

    always_comb begin
        state_d      = state_q;
        row_d        = row_q;
        col_d        = col_q;
        addr_d       = addr_q;
        shift_d      = shift_q;
        cnt_d        = cnt_q;
        wa_d         = wa_q;
        wd_d         = wd_q;
        pend_row_d   = pend_row_q;
        pend_col_d   = pend_col_q;
        pend_addr_d  = pend_addr_q;
        pend_print_d = pend_print_q;
        case (state_q)
            S_IDLE: begin
                if (take) begin
                    if (code_data == SC_BREAK) begin
                        state_d = S_BREAK;
                    end else if (code_data == SC_EXT) begin
                        state_d = S_EXT;
                    end else if (is_shift(code_data)) begin
                        shift_d = 1'b1;
                    end else if (code_data == SC_ENTER) begin
                        col_d = 7'd0;
                        if (row_q == LAST_ROW) begin
                            row_d  = 5'd0;
                            addr_d = '0;
                        end else begin
                            // start of the next row without a multiply
                            row_d  = row_q + 5'd1;
                            addr_d = addr_q - ADDR_W'(col_q) + COLS_A;
                        end
                    end else if (code_data == SC_BKSP) begin
                        if (col_q != 7'd0) begin
                            pend_row_d = row_q;
                            pend_col_d = col_q - 7'd1;
                        end else if (row_q != 5'd0) begin
                            pend_row_d = row_q - 5'd1;
                            pend_col_d = LAST_COL;
                        end else begin
                            pend_row_d = 5'd0;
                            pend_col_d = 7'd0;
                        end
                        pend_addr_d  = (addr_q == '0) ? '0 : addr_q - ONE_A;
                        pend_print_d = 1'b0;
                        wa_d         = (addr_q == '0) ? '0 : addr_q - ONE_A;
                        wd_d         = ASCII_SPACE;
                        state_d      = S_WRITE;
                    end else if (ascii != 8'h00) begin
                        if (col_q != LAST_COL) begin
                            pend_row_d  = row_q;
                            pend_col_d  = col_q + 7'd1;
                            pend_addr_d = addr_q + ONE_A;
                        end else if (row_q != LAST_ROW) begin
                            pend_row_d  = row_q + 5'd1;
                            pend_col_d  = 7'd0;
                            pend_addr_d = addr_q + ONE_A;
                        end else begin
                            pend_row_d  = 5'd0;
                            pend_col_d  = 7'd0;
                            pend_addr_d = '0;
                        end
                        pend_print_d = 1'b1;
                        wa_d         = addr_q;
                        wd_d         = ascii;
                        state_d      = S_WRITE;
                    end
                end
            end
            S_BREAK: begin
                if (take) begin
                    if (is_shift(code_data)) shift_d = 1'b0;
                    state_d = S_IDLE;
                end
            end
            S_EXT: begin
                if (take) begin
                    if (code_data == SC_BREAK) begin
                        state_d = S_BREAK;
                    end else begin
                        state_d = S_IDLE;
`ifdef PS2_TEXT_WRITER_ARROW_EN
                        case (code_data)
                            SC_UP: begin
                                if (row_q != 5'd0) begin
                                    row_d  = row_q - 5'd1;
                                    addr_d = addr_q - COLS_A;
                                end
                            end
                            SC_DOWN: begin
                                if (row_q != LAST_ROW) begin
                                    row_d  = row_q + 5'd1;
                                    addr_d = addr_q + COLS_A;
                                end
                            end
                            SC_LEFT: begin
                                if (col_q != 7'd0) begin
                                    col_d  = col_q - 7'd1;
                                    addr_d = addr_q - ONE_A;
                                end
                            end
                            SC_RIGHT: begin
                                if (col_q != LAST_COL) begin
                                    col_d  = col_q + 7'd1;
                                    addr_d = addr_q + ONE_A;
                                end
                            end
                            default: ;
                        endcase
`endif
                    end
                end
            end
            S_WRITE: begin
                row_d   = pend_row_q;
                col_d   = pend_col_q;
                addr_d  = pend_addr_q;
                if (pend_print_q) cnt_d = cnt_q + 8'd1;
                state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            row_q        <= '0;
            col_q        <= '0;
            addr_q       <= '0;
            shift_q      <= 1'b0;
            cnt_q        <= '0;
            wa_q         <= '0;
            wd_q         <= '0;
            pend_row_q   <= '0;
            pend_col_q   <= '0;
            pend_addr_q  <= '0;
            pend_print_q <= 1'b0;
        end else begin
            row_q        <= row_d;
            col_q        <= col_d;
            addr_q       <= addr_d;
            shift_q      <= shift_d;
            cnt_q        <= cnt_d;
            wa_q         <= wa_d;
            wd_q         <= wd_d;
            pend_row_q   <= pend_row_d;
            pend_col_q   <= pend_col_d;
            pend_addr_q  <= pend_addr_d;
            pend_print_q <= pend_print_d;
        end
    end

endmodule
